// File: rtl/mem_frame_reader.sv
// Raster-order reader for the single-port 8-bit frame SRAM.
// Issues credit-checked reads and streams pixels with x/y/last tags through a small FIFO.
module mem_frame_reader #(
    parameter int unsigned ADDR_BITS  = 19,
    parameter int unsigned DIM_BITS   = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [DIM_BITS-1:0]  img_w,
    input  logic [DIM_BITS-1:0]  img_h,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_we,
    input  logic [7:0]           mem_rdata,
    output logic [7:0]           pix_data,
    output logic [DIM_BITS-1:0]  pix_x,
    output logic [DIM_BITS-1:0]  pix_y,
    output logic                 pix_last,
    output logic                 pix_valid,
    input  logic                 pix_ready
);

    localparam int unsigned PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_BITS = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_BITS = CNT_BITS + 2;

    localparam logic [ADDR_BITS-1:0] ADDR_ONE = 1;
    localparam logic [DIM_BITS-1:0]  DIM_ONE  = 1;
    localparam logic [PTR_BITS-1:0]  PTR_ONE  = 1;
    localparam logic [CNT_BITS-1:0]  CNT_ONE  = 1;
    localparam logic [OCC_BITS-1:0]  DEPTH_C  = OCC_BITS'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFinish} state_e;

    state_e state_q, state_d;

    logic [DIM_BITS-1:0]  w_q, h_q, x_q, y_q;
    logic [ADDR_BITS-1:0] addr_cnt_q, mem_addr_q;

    // Tag pipeline: stage 0 = address on the SRAM bus, stage 1 = data on mem_rdata.
    logic                v0_q, v1_q, l0_q, l1_q;
    logic [DIM_BITS-1:0] x0_q, y0_q, x1_q, y1_q;

    logic [7:0]          fifo_data_q [FIFO_DEPTH];
    logic [DIM_BITS-1:0] fifo_x_q    [FIFO_DEPTH];
    logic [DIM_BITS-1:0] fifo_y_q    [FIFO_DEPTH];
    logic                fifo_last_q [FIFO_DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_BITS-1:0] count_q;

    logic                start_ok, zero_dim, x_end, at_last, credit, issue, push, pop;
    logic [OCC_BITS-1:0] occupancy;

    assign start_ok  = (state_q == StIdle) && start;
    assign zero_dim  = (img_w == '0) || (img_h == '0);
    assign x_end     = (x_q == w_q - DIM_ONE);
    assign at_last   = x_end && (y_q == h_q - DIM_ONE);
    // Reads already in flight reserve a FIFO slot, so the FIFO can never overflow.
    assign occupancy = OCC_BITS'(count_q) + OCC_BITS'(v0_q) + OCC_BITS'(v1_q);
    assign credit    = occupancy < DEPTH_C;
    assign issue     = (state_q == StIssue) && credit;
    assign push      = v1_q;
    assign pop       = pix_valid && pix_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = zero_dim ? StFinish : StIssue;
            StIssue:  if (issue && at_last) state_d = StDrain;
            StDrain:  if ((count_q == '0) && !v0_q && !v1_q) state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            w_q        <= '0;
            h_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            addr_cnt_q <= '0;
            mem_addr_q <= '0;
            v0_q       <= 1'b0;
            v1_q       <= 1'b0;
            l0_q       <= 1'b0;
            l1_q       <= 1'b0;
            x0_q       <= '0;
            y0_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                w_q        <= img_w;
                h_q        <= img_h;
                addr_cnt_q <= base_addr;
                x_q        <= '0;
                y_q        <= '0;
            end
            if (issue) begin
                mem_addr_q <= addr_cnt_q;
                addr_cnt_q <= addr_cnt_q + ADDR_ONE;
                if (x_end) begin
                    x_q <= '0;
                    y_q <= y_q + DIM_ONE;
                end else begin
                    x_q <= x_q + DIM_ONE;
                end
            end
            v0_q <= issue;
            x0_q <= x_q;
            y0_q <= y_q;
            l0_q <= at_last;
            v1_q <= v0_q;
            x1_q <= x0_q;
            y1_q <= y0_q;
            l1_q <= l0_q;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_rdata;
            fifo_x_q[wr_ptr_q]    <= x1_q;
            fifo_y_q[wr_ptr_q]    <= y1_q;
            fifo_last_q[wr_ptr_q] <= l1_q;
        end
    end

    assign busy      = (state_q == StIssue) || (state_q == StDrain);
    assign done      = (state_q == StFinish);
    assign mem_addr  = mem_addr_q;
    assign mem_we    = 1'b0;
    assign pix_valid = (count_q != '0);
    // Gate the head with valid so an empty FIFO presents zeros.
    assign pix_data  = pix_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign pix_x     = pix_valid ? fifo_x_q[rd_ptr_q] : '0;
    assign pix_y     = pix_valid ? fifo_y_q[rd_ptr_q] : '0;
    assign pix_last  = pix_valid && fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_mem_frame_reader.sv
// Directed self-checking bench for mem_frame_reader with a behavioural 1-cycle SRAM.
// Each scenario task checks its own results against hand-derived expectations.
module tb_mem_frame_reader;

    localparam int AB = 19;
    localparam int DB = 10;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AB-1:0] base_addr = '0;
    logic [DB-1:0] img_w = '0;
    logic [DB-1:0] img_h = '0;
    logic          busy, done, mem_we, pix_last, pix_valid;
    logic [AB-1:0] mem_addr;
    logic [7:0]    mem_rdata = '0;
    logic [7:0]    pix_data;
    logic [DB-1:0] pix_x, pix_y;
    logic          pix_ready = 1'b0;

    mem_frame_reader #(
        .ADDR_BITS (AB),
        .DIM_BITS  (DB),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .img_w    (img_w),
        .img_h    (img_h),
        .busy     (busy),
        .done     (done),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata),
        .pix_data (pix_data),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .pix_last (pix_last),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready)
    );

    always #5 clk = ~clk;

    // SRAM contents are a fixed function of the address.
    function automatic logic [7:0] pat(input logic [AB-1:0] a);
        return a[7:0] ^ {a[10:8], a[18:14]} ^ 8'h5A;
    endfunction

    int cyc = 0;
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        mem_rdata <= pat(mem_addr);
    end

    // 0: ready low, 1: ready high, 2: random ready
    int ready_mode = 1;
    initial forever begin
        @(posedge clk);
        #2;
        pix_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end

    // Monitor log, sampled on the falling edge.
    logic [7:0] tq_data[$];
    int tq_x[$], tq_y[$], tq_last[$], tq_cyc[$], addr_q[$];
    int done_cnt = 0, done_cyc = -1, we_seen = 0, stall_viol = 0, valid_seen = 0, busy_seen = 0;

    initial begin
        logic          prev_stall;
        logic [7:0]    prev_data;
        logic [DB-1:0] prev_x, prev_y;
        logic          prev_last;
        logic [AB-1:0] prev_addr;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_x     = '0;
        prev_y     = '0;
        prev_last  = 1'b0;
        prev_addr  = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pix_valid && pix_ready) begin
                    tq_data.push_back(pix_data);
                    tq_x.push_back(int'(pix_x));
                    tq_y.push_back(int'(pix_y));
                    tq_last.push_back(int'(pix_last));
                    tq_cyc.push_back(cyc);
                end
                if (pix_valid) valid_seen++;
                if (busy) busy_seen++;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (prev_stall && (!pix_valid || pix_data !== prev_data || pix_x !== prev_x ||
                                   pix_y !== prev_y || pix_last !== prev_last))
                    stall_viol++;
                if (mem_addr !== prev_addr) addr_q.push_back(int'(mem_addr));
            end
            if (mem_we !== 1'b0) we_seen++;
            prev_stall = rst_n && pix_valid && !pix_ready;
            prev_data  = pix_data;
            prev_x     = pix_x;
            prev_y     = pix_y;
            prev_last  = pix_last;
            prev_addr  = mem_addr;
        end
    end

    int n_cmp = 0, n_fail = 0;
    int t0, a0, d0, vs0, sv0, bs0, e0;

    task automatic snap();
        t0  = tq_data.size();
        a0  = addr_q.size();
        d0  = done_cnt;
        vs0 = valid_seen;
        sv0 = stall_viol;
        bs0 = busy_seen;
    endtask

    task automatic start_frame(input int b, input int w, input int h);
        @(posedge clk);
        #1;
        base_addr = AB'(b);
        img_w     = DB'(w);
        img_h     = DB'(h);
        start     = 1'b1;
        e0        = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_cmp++;
        if (done_cnt == d0) begin
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, mem_we, pix_valid, pix_last} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000", {busy, done, mem_we, pix_valid, pix_last});
        end
        n_cmp++;
        if (mem_addr !== '0 || pix_data !== '0 || pix_x !== '0 || pix_y !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%0d data=%0d x=%0d y=%0d want 0", mem_addr, pix_data,
                     pix_x, pix_y);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int k;
        ready_mode = 1;
        snap();
        start_frame(100, 4, 2);
        wait_done(60);
        n_cmp++;
        if (tq_data.size() - t0 != 8) begin
            n_fail++;
            $display("FAIL basic_count: got %0d want 8", tq_data.size() - t0);
        end
        for (int i = 0; i < 8; i++) begin
            k = t0 + i;
            n_cmp++;
            if (k >= tq_data.size()) begin
                n_fail++;
                $display("FAIL basic_pix%0d: missing", i);
            end else if (tq_data[k] !== pat(AB'(100 + i)) || tq_x[k] != i % 4 || tq_y[k] != i / 4 ||
                         tq_last[k] != int'(i == 7) || tq_cyc[k] != e0 + 3 + i) begin
                n_fail++;
                $display("FAIL basic_pix%0d: got d=%0d x=%0d y=%0d l=%0d c=%0d want d=%0d x=%0d y=%0d l=%0d c=%0d",
                         i, tq_data[k], tq_x[k], tq_y[k], tq_last[k], tq_cyc[k] - e0,
                         pat(AB'(100 + i)), i % 4, i / 4, int'(i == 7), 3 + i);
            end
        end
        n_cmp++;
        if (valid_seen - vs0 != 8) begin
            n_fail++;
            $display("FAIL basic_valid_cycles: got %0d want 8", valid_seen - vs0);
        end
        n_cmp++;
        if (done_cnt - d0 != 1 || tq_data.size() < t0 + 8 || done_cyc != tq_cyc[t0 + 7] + 2) begin
            n_fail++;
            $display("FAIL basic_done: pulses=%0d at=%0d want 1 at %0d", done_cnt - d0,
                     done_cyc - e0, 12);
        end
    endtask

    task automatic test_backpressure();
        int k, lasts;
        ready_mode = 2;
        snap();
        start_frame(2000, 8, 4);
        wait_done(400);
        ready_mode = 1;
        n_cmp++;
        if (tq_data.size() - t0 != 32) begin
            n_fail++;
            $display("FAIL bp_count: got %0d want 32", tq_data.size() - t0);
        end
        lasts = 0;
        for (int i = 0; i < 32; i++) begin
            k = t0 + i;
            n_cmp++;
            if (k >= tq_data.size()) begin
                n_fail++;
                $display("FAIL bp_pix%0d: missing", i);
            end else begin
                lasts += tq_last[k];
                if (tq_data[k] !== pat(AB'(2000 + i)) || tq_x[k] != i % 8 || tq_y[k] != i / 8 ||
                    tq_last[k] != int'(i == 31)) begin
                    n_fail++;
                    $display("FAIL bp_pix%0d: got d=%0d x=%0d y=%0d l=%0d want d=%0d x=%0d y=%0d l=%0d",
                             i, tq_data[k], tq_x[k], tq_y[k], tq_last[k], pat(AB'(2000 + i)),
                             i % 8, i / 8, int'(i == 31));
                end
            end
        end
        n_cmp++;
        if (lasts != 1) begin
            n_fail++;
            $display("FAIL bp_last_count: got %0d want 1", lasts);
        end
        n_cmp++;
        if (stall_viol - sv0 != 0) begin
            n_fail++;
            $display("FAIL bp_stall_stable: got %0d violations want 0", stall_viol - sv0);
        end
        n_cmp++;
        if (we_seen != 0 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL bp_we_done: we=%0d done=%0d want 0 and 1", we_seen, done_cnt - d0);
        end
    endtask

    task automatic test_zero_dim();
        logic [AB-1:0] saved;
        saved = mem_addr;
        snap();
        start_frame(700, 0, 5);
        wait_done(10);
        n_cmp++;
        if (done_cnt - d0 != 1 || done_cyc != e0) begin
            n_fail++;
            $display("FAIL zero_done: pulses=%0d at=%0d want 1 at 0", done_cnt - d0, done_cyc - e0);
        end
        n_cmp++;
        if (mem_addr !== saved || addr_q.size() != a0) begin
            n_fail++;
            $display("FAIL zero_addr: got %0d (%0d changes) want %0d", mem_addr,
                     addr_q.size() - a0, saved);
        end
        n_cmp++;
        if (valid_seen != vs0 || busy_seen != bs0) begin
            n_fail++;
            $display("FAIL zero_quiet: valid=%0d busy=%0d want 0 0", valid_seen - vs0,
                     busy_seen - bs0);
        end
    endtask

    task automatic test_wrap();
        int exp_a[4];
        int k;
        exp_a = '{524286, 524287, 0, 1};
        snap();
        start_frame(524286, 4, 1);
        wait_done(40);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (a0 + i >= addr_q.size() || addr_q[a0 + i] != exp_a[i]) begin
                n_fail++;
                $display("FAIL wrap_addr%0d: got %0d want %0d", i,
                         (a0 + i < addr_q.size()) ? addr_q[a0 + i] : -1, exp_a[i]);
            end
            k = t0 + i;
            n_cmp++;
            if (k >= tq_data.size() || tq_data[k] !== pat(AB'(exp_a[i])) || tq_x[k] != i ||
                tq_last[k] != int'(i == 3)) begin
                n_fail++;
                $display("FAIL wrap_pix%0d: got d=%0d want d=%0d", i,
                         (k < tq_data.size()) ? tq_data[k] : 8'hxx, pat(AB'(exp_a[i])));
            end
        end
    endtask

    task automatic test_reset_mid();
        int n, k;
        ready_mode = 1;
        snap();
        start_frame(40, 4, 4);
        n = 0;
        while (tq_data.size() - t0 < 5 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (tq_data.size() - t0 != 5) begin
            n_fail++;
            $display("FAIL rstmid_xfers: got %0d want 5", tq_data.size() - t0);
        end
        n_cmp++;
        if ({busy, done, pix_valid, pix_last} !== 4'b0 || mem_addr !== '0 || pix_data !== '0 ||
            pix_x !== '0 || pix_y !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: ctrl=%b addr=%0d data=%0d x=%0d y=%0d want all 0",
                     {busy, done, pix_valid, pix_last}, mem_addr, pix_data, pix_x, pix_y);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (done_cnt != d0) begin
            n_fail++;
            $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt - d0);
        end
        snap();
        start_frame(300, 2, 2);
        wait_done(40);
        for (int i = 0; i < 4; i++) begin
            k = t0 + i;
            n_cmp++;
            if (k >= tq_data.size() || tq_data[k] !== pat(AB'(300 + i)) || tq_x[k] != i % 2 ||
                tq_y[k] != i / 2 || tq_last[k] != int'(i == 3)) begin
                n_fail++;
                $display("FAIL rstmid_pix%0d: got d=%0d want d=%0d", i,
                         (k < tq_data.size()) ? tq_data[k] : 8'hxx, pat(AB'(300 + i)));
            end
        end
        n_cmp++;
        if (tq_data.size() - t0 != 4 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL rstmid_frame2: xfers=%0d done=%0d want 4 and 1", tq_data.size() - t0,
                     done_cnt - d0);
        end
    endtask

    task automatic test_busy_restart();
        int outst, max_out, k;
        ready_mode = 0;
        snap();
        start_frame(1000, 4, 4);
        @(posedge clk);
        #1;
        base_addr = AB'(5000);
        img_w     = DB'(2);
        img_h     = DB'(2);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        max_out = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            outst = (addr_q.size() - a0) - (tq_data.size() - t0);
            if (outst > max_out) max_out = outst;
        end
        n_cmp++;
        if (max_out > FD || addr_q.size() - a0 != FD) begin
            n_fail++;
            $display("FAIL restart_credit: max_out=%0d issued=%0d want <=%0d and %0d", max_out,
                     addr_q.size() - a0, FD, FD);
        end
        n_cmp++;
        if (busy !== 1'b1 || pix_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_stalled: busy=%b valid=%b want 1 1", busy, pix_valid);
        end
        ready_mode = 1;
        wait_done(100);
        for (int i = 0; i < 16; i++) begin
            k = t0 + i;
            n_cmp++;
            if (k >= tq_data.size() || tq_data[k] !== pat(AB'(1000 + i)) || tq_x[k] != i % 4 ||
                tq_y[k] != i / 4 || tq_last[k] != int'(i == 15)) begin
                n_fail++;
                $display("FAIL restart_pix%0d: got d=%0d want d=%0d", i,
                         (k < tq_data.size()) ? tq_data[k] : 8'hxx, pat(AB'(1000 + i)));
            end
        end
        n_cmp++;
        if (tq_data.size() - t0 != 16 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL restart_frame: xfers=%0d done=%0d want 16 and 1", tq_data.size() - t0,
                     done_cnt - d0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_dim();
        test_wrap();
        test_reset_mid();
        test_busy_restart();
        n_cmp++;
        if (we_seen != 0) begin
            n_fail++;
            $display("FAIL mem_we_low: got %0d cycles high want 0", we_seen);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
